seq_divider: RTL

- Sequential unsigned restoring divider. It is the inverse of the team's repeated-addition multiplier and complements it in the arithmetic datapath.
- Operands arrive over the same shared data_in bus style: dividend on the first cycle, divisor on the next.
- Internally split into a datapath (dividend shift register, divisor register, partial-remainder register, subtractor, iteration counter) and an FSM controller.
- Produces one quotient bit per cycle, then asserts done with quotient and remainder held stable.

---
 rtl/seq_divider.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock.
//
// Operands arrive on the shared data_in bus. The dividend is taken with start,
// and the divisor is taken on the following edge. A nonzero divisor then takes
// WIDTH restoring steps. The results are registered when the FSM enters DONE,
// and they stay stable until the next completion or a reset.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start; outputs hold
//   LOAD_B | dividend latched; sampling divisor (zero divisor short-cuts to DONE)
//   CALC   | one restoring step per edge, WIDTH steps total
//   DONE   | results valid, done high; start relaunches
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        launch request, honoured in IDLE or DONE only
//   data_in      operand bus (dividend with start, divisor on the next edge)
//   quotient     registered quotient
//   remainder    registered remainder
//   busy         high in LOAD_B and CALC
//   done         high in DONE
//   div_by_zero  high in DONE when the divisor was zero
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q;   // dividend, shifted left one bit per step
  logic [WIDTH-1:0] b_q;   // divisor
  logic [WIDTH-1:0] r_q;   // partial remainder
  logic [WIDTH-1:0] q_q;   // quotient being assembled
  logic [CW-1:0]    cnt;
  logic             dz_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             launch;
  logic             last_step;

  assign launch    = ((state == IDLE) || (state == DONE)) && start;
  assign last_step = (cnt == LAST_STEP);

  // A borrow out of the subtract, seen in trial[WIDTH], means the divisor did
  // not fit. In that case the shifted remainder is restored. A partial
  // remainder below the divisor keeps the dropped MSB of r_q at zero.
  assign trial  = {r_q, a_q[WIDTH-1]} - {1'b0, b_q};
  assign r_next = trial[WIDTH] ? {r_q[WIDTH-2:0], a_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign q_next = {q_q[WIDTH-2:0], ~trial[WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD_B;
      LOAD_B:  state_nx = (data_in == '0) ? DONE : CALC;
      CALC:    if (last_step) state_nx = DONE;
      DONE:    if (start) state_nx = LOAD_B;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      cnt       <= '0;
      dz_q      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (launch) begin
            a_q  <= data_in;
            r_q  <= '0;
            q_q  <= '0;
            cnt  <= '0;
            dz_q <= 1'b0;
          end
        end
        LOAD_B: begin
          if (data_in == '0) begin
            quotient  <= '1;
            remainder <= a_q;
            dz_q      <= 1'b1;
          end else begin
            b_q <= data_in;
          end
        end
        CALC: begin
          a_q <= a_q << 1;
          r_q <= r_next;
          q_q <= q_next;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state == LOAD_B) || (state == CALC);
  assign done        = (state == DONE);
  assign div_by_zero = dz_q;

endmodule
